// File: rtl/dps_utim64_pkg.sv
// Shared definitions for the UTIM64 timer unit: state encoding, DQM half
// indices and the wrap constant, reused by the comparator counters.
package dps_utim64_pkg;

  typedef enum logic {
    UTIM64_ST_STOP = 1'b0,
    UTIM64_ST_RUN  = 1'b1
  } utim64_state_e;

  localparam logic UTIM64_DQM_LO = 1'b0;
  localparam logic UTIM64_DQM_HI = 1'b1;

  localparam logic [63:0] UTIM64_COUNT_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/dps_utim64_prescaler.sv
// Prescaler for the UTIM64 main counter: emits a one-cycle tick every DIV+1
// clocks while running.
module dps_utim64_prescaler #(
  parameter int unsigned P_DIV_WIDTH = 16
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic                   iRUN,
  input  logic                   iCLEAR,
  input  logic [P_DIV_WIDTH-1:0] iDIV,
  output logic                   oTICK
);

  logic [P_DIV_WIDTH-1:0] psc_q, psc_d;
  logic                   hit;

  always_comb begin
    hit   = (psc_q == iDIV);
    // A clear (config write or load) restarts the period and swallows any due tick.
    oTICK = iRUN & ~iCLEAR & hit;
    if (!iRUN || iCLEAR || hit) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + {{(P_DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/dps_utim64_main_counter.sv
// UTIM64 free-running 64-bit main timer: run/stop FSM, masked load, sticky
// overflow with IRQ and a coherent snapshot for 32-bit bus reads.
module dps_utim64_main_counter
  import dps_utim64_pkg::*;
#(
  parameter int unsigned P_DIV_WIDTH = 16
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic                   iCONF_WRITE,
  input  logic                   iCONF_ENA,
  input  logic                   iCONF_IRQENA,
  input  logic [P_DIV_WIDTH-1:0] iCONF_DIV,
  input  logic                   iCOUNT_WRITE,
  input  logic [1:0]             inCOUNT_DQM,
  input  logic [63:0]            iCOUNT_COUNTER,
  input  logic                   iOVF_CLEAR,
  input  logic                   iSNAP_REQ,
  output logic                   oWORKING,
  output logic [63:0]            oCOUNT,
  output logic                   oOVF,
  output logic                   oIRQ,
  output logic [63:0]            oSNAP_COUNT,
  output logic                   oSNAP_VALID
);

  utim64_state_e          state_q, state_d;
  logic                   enable_q, irqena_q;
  logic [P_DIV_WIDTH-1:0] div_q;
  logic [63:0]            count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [63:0]            snap_q;
  logic                   snap_valid_q;
  logic                   run, tick;

  // Ticks stop as soon as enable drops, one cycle before the FSM reaches STOP.
  assign run = (state_q == UTIM64_ST_RUN) && enable_q;

  dps_utim64_prescaler #(
    .P_DIV_WIDTH (P_DIV_WIDTH)
  ) u_prescaler (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .iRUN   (run),
    .iCLEAR (iCONF_WRITE | iCOUNT_WRITE),
    .iDIV   (div_q),
    .oTICK  (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UTIM64_ST_STOP: if (enable_q)  state_d = UTIM64_ST_RUN;
      UTIM64_ST_RUN:  if (!enable_q) state_d = UTIM64_ST_STOP;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (iCOUNT_WRITE) begin
      if (!inCOUNT_DQM[UTIM64_DQM_LO]) count_d[31:0]  = iCOUNT_COUNTER[31:0];
      if (!inCOUNT_DQM[UTIM64_DQM_HI]) count_d[63:32] = iCOUNT_COUNTER[63:32];
    end else if (tick) begin
      count_d = count_q + 64'd1;
    end
    // Set beats a same-cycle clear.
    ovf_d = (tick && (count_q == UTIM64_COUNT_MAX)) || (ovf_q && !iOVF_CLEAR);
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q      <= UTIM64_ST_STOP;
      enable_q     <= 1'b0;
      irqena_q     <= 1'b0;
      div_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= iSNAP_REQ;
      if (iCONF_WRITE) begin
        enable_q <= iCONF_ENA;
        irqena_q <= iCONF_IRQENA;
        div_q    <= iCONF_DIV;
      end
      if (iSNAP_REQ) begin
        snap_q <= count_q;
      end
    end
  end

  assign oWORKING    = (state_q == UTIM64_ST_RUN);
  assign oCOUNT      = count_q;
  assign oOVF        = ovf_q;
  assign oIRQ        = irqena_q & ovf_q;
  assign oSNAP_COUNT = snap_q;
  assign oSNAP_VALID = snap_valid_q;

endmodule

// File: tb/tb_dps_utim64_main_counter.sv
// Directed, table-driven bench for dps_utim64_main_counter plus hand-written
// sequences for async reset and prescaler timing.
module tb_dps_utim64_main_counter;

  localparam int unsigned DW = 16;

  logic          iCLOCK, inRESET;
  logic          iCONF_WRITE, iCONF_ENA, iCONF_IRQENA;
  logic [DW-1:0] iCONF_DIV;
  logic          iCOUNT_WRITE;
  logic [1:0]    inCOUNT_DQM;
  logic [63:0]   iCOUNT_COUNTER;
  logic          iOVF_CLEAR, iSNAP_REQ;
  logic          oWORKING, oOVF, oIRQ, oSNAP_VALID;
  logic [63:0]   oCOUNT, oSNAP_COUNT;

  dps_utim64_main_counter #(
    .P_DIV_WIDTH(DW)
  ) dut (
    .iCLOCK        (iCLOCK),
    .inRESET       (inRESET),
    .iCONF_WRITE   (iCONF_WRITE),
    .iCONF_ENA     (iCONF_ENA),
    .iCONF_IRQENA  (iCONF_IRQENA),
    .iCONF_DIV     (iCONF_DIV),
    .iCOUNT_WRITE  (iCOUNT_WRITE),
    .inCOUNT_DQM   (inCOUNT_DQM),
    .iCOUNT_COUNTER(iCOUNT_COUNTER),
    .iOVF_CLEAR    (iOVF_CLEAR),
    .iSNAP_REQ     (iSNAP_REQ),
    .oWORKING      (oWORKING),
    .oCOUNT        (oCOUNT),
    .oOVF          (oOVF),
    .oIRQ          (oIRQ),
    .oSNAP_COUNT   (oSNAP_COUNT),
    .oSNAP_VALID   (oSNAP_VALID)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic          cw, ena, irqe;
    logic [DW-1:0] div;
    logic          lw;
    logic [1:0]    dqm;
    logic [63:0]   val;
    logic          oclr, snap;
    logic          e_work;
    logic [63:0]   e_count;
    logic          e_ovf, e_irq;
    logic [63:0]   e_snap;
    logic          e_sv;
  } vec_t;

  vec_t vecs[$];
  int   n_run, n_fail;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic vec_t v(input logic cw, ena, irqe, input logic [DW-1:0] div,
                             input logic lw, input logic [1:0] dqm, input logic [63:0] val,
                             input logic oclr, snap, e_work, input logic [63:0] e_count,
                             input logic e_ovf, e_irq, input logic [63:0] e_snap,
                             input logic e_sv);
    vec_t r;
    r.cw = cw; r.ena = ena; r.irqe = irqe; r.div = div; r.lw = lw; r.dqm = dqm;
    r.val = val; r.oclr = oclr; r.snap = snap; r.e_work = e_work; r.e_count = e_count;
    r.e_ovf = e_ovf; r.e_irq = e_irq; r.e_snap = e_snap; r.e_sv = e_sv;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iCONF_WRITE = 0; iCONF_ENA = 0; iCONF_IRQENA = 0; iCONF_DIV = '0;
    iCOUNT_WRITE = 0; inCOUNT_DQM = 2'b11; iCOUNT_COUNTER = '0;
    iOVF_CLEAR = 0; iSNAP_REQ = 0;
  endtask

  task automatic chk_all(input string tag, input logic w, input logic [63:0] c,
                         input logic ovf, input logic irq, input logic [63:0] s,
                         input logic sv);
    chk({tag, " working"}, oWORKING, w);
    chk({tag, " count"}, oCOUNT, c);
    chk({tag, " ovf"}, oOVF, ovf);
    chk({tag, " irq"}, oIRQ, irq);
    chk({tag, " snap"}, oSNAP_COUNT, s);
    chk({tag, " snap_valid"}, oSNAP_VALID, sv);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    idle_inputs();
    inRESET = 1'b0;

    //        cw ena irq div lw dqm    val                     oc sn  w  count                   ov iq snap sv
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 0, 64'd0,                 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 0, 64'd0,                 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd0,                 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd1,                 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd2,                 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd3,                 0, 0, 0, 0));
    // DIV=3: one tick every fourth clock after the config write.
    vecs.push_back(v(1, 1, 0, 3, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd3,                 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,               0, 0, 1, 64'd3,                 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd4,                 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,               0, 0, 1, 64'd4,                 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd5,                 0, 0, 0, 0));
    // 64-bit wrap with IRQ enabled, then clear.
    vecs.push_back(v(1, 1, 1, 0, 1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, ONES,                  0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd0,                 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd1,                 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 1, 0, 1, 64'd2,                 0, 0, 0, 0));
    // Stop: no tick on the write, FSM leaves RUN one edge later.
    vecs.push_back(v(1, 0, 1, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd2,                 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 0, 64'd2,                 0, 0, 0, 0));
    // Masked loads while stopped.
    vecs.push_back(v(0, 0, 0, 0, 1, 2'b00, 64'h0000_0005_0000_0010, 0, 0, 0, 64'h0000_0005_0000_0010, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 2'b01, 64'hAAAA_AAAA_0000_0000, 0, 0, 0, 64'hAAAA_AAAA_0000_0010, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 2'b10, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 64'hAAAA_AAAA_9ABC_DEF0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 2'b11, 64'd0,                 0, 0, 0, 64'hAAAA_AAAA_9ABC_DEF0, 0, 0, 0, 0));
    // Load + config in one cycle, restart, snapshots.
    vecs.push_back(v(1, 1, 1, 0, 1, 2'b00, 64'd99,                0, 0, 0, 64'd99,                0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd99,                0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd100,               0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 1, 1, 64'd101,               0, 0, 100, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 1, 1, 64'd102,               0, 0, 101, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd103,               0, 0, 101, 0));
    // Low-half wrap must not flag overflow.
    vecs.push_back(v(0, 0, 0, 0, 1, 2'b10, 64'h0000_0000_FFFF_FFFF, 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 0, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'h0000_0001_0000_0000, 0, 0, 101, 0));
    // Wrap coinciding with clear: set wins.
    vecs.push_back(v(0, 0, 0, 0, 1, 2'b00, ONES,                  0, 0, 1, ONES,                  0, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 1, 0, 1, 64'd0,                 1, 1, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 1, 0, 1, 64'd1,                 0, 0, 101, 0));
    // DIV=1: load wins over a due tick, next tick two clocks later.
    vecs.push_back(v(1, 1, 0, 1, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd1,                 0, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd1,                 0, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 2'b00, 64'h500,               0, 0, 1, 64'h500,               0, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'h500,               0, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'h501,               0, 0, 101, 0));
    // Wrap with IRQ masked: flag recorded, no IRQ.
    vecs.push_back(v(0, 0, 0, 0, 1, 2'b00, ONES,                  0, 0, 1, ONES,                  0, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, ONES,                  0, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 0, 0, 1, 64'd0,                 1, 0, 101, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2'b11, 64'd0,                 1, 0, 1, 64'd0,                 0, 0, 101, 0));

    repeat (2) @(posedge iCLOCK);
    #1;
    chk_all("reset", 0, 64'd0, 0, 0, 64'd0, 0);
    inRESET = 1'b1;

    foreach (vecs[i]) begin
      iCONF_WRITE = vecs[i].cw; iCONF_ENA = vecs[i].ena; iCONF_IRQENA = vecs[i].irqe;
      iCONF_DIV = vecs[i].div; iCOUNT_WRITE = vecs[i].lw; inCOUNT_DQM = vecs[i].dqm;
      iCOUNT_COUNTER = vecs[i].val; iOVF_CLEAR = vecs[i].oclr; iSNAP_REQ = vecs[i].snap;
      @(posedge iCLOCK);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_work, vecs[i].e_count, vecs[i].e_ovf,
              vecs[i].e_irq, vecs[i].e_snap, vecs[i].e_sv);
    end

    // Asynchronous reset while running with a snapshot pulse in flight.
    idle_inputs();
    iCOUNT_WRITE = 1; inCOUNT_DQM = 2'b00; iCOUNT_COUNTER = 64'hDEAD; iSNAP_REQ = 1;
    @(posedge iCLOCK);
    #1;
    idle_inputs();
    iSNAP_REQ = 1;
    @(posedge iCLOCK);
    #1;
    idle_inputs();
    chk_all("pre_reset", 1, 64'hDEAD, 0, 0, 64'hDEAD, 1);
    #2;
    inRESET = 1'b0;
    #1;
    chk_all("async_reset", 0, 64'd0, 0, 0, 64'd0, 0);
    @(posedge iCLOCK);
    #2;
    inRESET = 1'b1;
    repeat (3) @(posedge iCLOCK);
    #1;
    chk("after_reset working", oWORKING, 1'b0);
    chk("after_reset count", oCOUNT, 64'd0);

    // DIV=2 from STOP: RUN entry one edge after the write, then ticks every 3 clocks.
    begin
      int n;
      bit hit;
      iCONF_WRITE = 1; iCONF_ENA = 1; iCONF_DIV = 2;
      @(posedge iCLOCK);
      #1;
      idle_inputs();
      n = 0;
      hit = 0;
      while (!hit && n < 40) begin
        @(posedge iCLOCK);
        #1;
        n++;
        if (oCOUNT == 64'd3) hit = 1;
      end
      if (!hit) begin
        n_run++;
        n_fail++;
        $display("FAIL div2_timeout: count %h never reached 3 within %0d cycles", oCOUNT, n);
      end else begin
        chk("div2 cycles_to_three", 64'(n), 64'd10);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dps_utim64_main_counter.md
Name: dps_utim64_main_counter

Overview:
- Free-running 64-bit main timer of the UTIM64 unit.
- Sits directly upstream of the per-channel comparator counters and drives their main-counter inputs:
  - oWORKING feeds their iMTIMER_WORKING.
  - oCOUNT feeds their iMTIMER_COUNT.
- Provides a programmable prescaler, start/stop control, masked software load, a sticky overflow flag with IRQ, and a coherent 64-bit snapshot for 32-bit bus reads.

Parameters:
- P_DIV_WIDTH, 16, width of the prescaler divide value and internal prescaler counter.

Ports:
- iCLOCK  in  1  system clock; everything is on its rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iCONF_WRITE  in  1  one-cycle strobe; latches iCONF_ENA, iCONF_IRQENA, iCONF_DIV.
- iCONF_ENA  in  1  1 = run, 0 = stop.
- iCONF_IRQENA  in  1  overflow interrupt enable.
- iCONF_DIV  in  P_DIV_WIDTH  count advances once every DIV+1 clocks.
- iCOUNT_WRITE  in  1  one-cycle strobe; loads the count.
- inCOUNT_DQM  in  2  active-low half mask; [0] covers bits 31:0, [1] covers bits 63:32.
- iCOUNT_COUNTER  in  64  load value.
- iOVF_CLEAR  in  1  clears the sticky overflow flag.
- iSNAP_REQ  in  1  captures oCOUNT into the snapshot register.
- oWORKING  out  1  1 while in RUN.
- oCOUNT  out  64  current count.
- oOVF  out  1  sticky 64-bit wrap flag.
- oIRQ  out  1  = irqena AND oOVF; combinational from registers.
- oSNAP_COUNT  out  64  captured count.
- oSNAP_VALID  out  1  one-cycle pulse, asserted the cycle after iSNAP_REQ.

Behaviour:
- Reset (async, inRESET=0):
  - State = STOP; enable = 0, irqena = 0, div = 0, psc = 0, count = 0, ovf = 0, snap = 0, snap_valid = 0.
  - All outputs read 0.
- Config write:
  - On iCONF_WRITE, enable, irqena and div take the input values on the next edge.
  - psc is cleared on every config write.
- State machine, two states:
  - STOP:
    - oWORKING = 0; count holds.
    - Goes to RUN on the edge after enable is seen as 1. First increment comes DIV+1 cycles after entering RUN.
  - RUN:
    - oWORKING = 1.
    - Each cycle: if psc == div, then psc <= 0 and count <= count + 1 (a tick); otherwise psc <= psc + 1.
    - div = 0 gives one increment per clock.
    - Goes to STOP on the edge after enable becomes 0. No tick occurs in the cycle the config write with ENA=0 is applied. Count holds its value; psc = 0.
- Count load:
  - iCOUNT_WRITE has priority over a same-cycle tick.
  - Half [31:0] is loaded when inCOUNT_DQM[0]=0; half [63:32] is loaded when inCOUNT_DQM[1]=0. A masked half holds the current count value.
  - psc is cleared on a load. A load is allowed in both STOP and RUN; state is unchanged.
  - A load and a config write in the same cycle both take effect.
- Arithmetic:
  - Unsigned 64-bit increment; a tick at 64'hFFFF_FFFF_FFFF_FFFF wraps the count to 0 and sets ovf.
  - A low-half wrap alone does not set ovf.
  - A load never sets ovf.
- Overflow flag:
  - ovf is sticky and cleared by iOVF_CLEAR.
  - If set and clear occur in the same cycle, set wins.
  - irqena = 0 masks oIRQ only; ovf still records the wrap.
- Snapshot:
  - iSNAP_REQ at edge N: snap <= count as registered before edge N (pre-tick value); snap_valid = 1 for the cycle after edge N.
  - Back-to-back requests give back-to-back pulses, each with its own value.
  - snap holds between requests.
- Reset mid-RUN: everything returns to reset values immediately (asynchronous); the block restarts in STOP.

Decomposition:
- Shared package dps_utim64_pkg holds:
  - state encoding constants UTIM64_ST_STOP / UTIM64_ST_RUN;
  - DQM bit indices UTIM64_DQM_LO = 0 and UTIM64_DQM_HI = 1;
  - the 64-bit all-ones wrap constant.
  The comparator counter reuses these.
- One natural sub-module, dps_utim64_prescaler:
  - Inputs: clock, reset, run, clear, div.
  - Output: one-cycle tick when psc == div.
- The parent owns the FSM, count, ovf and snapshot.

Test Plan:
- Reset, then config write ENA=1, DIV=0 -> oWORKING=1 from the next cycle; oCOUNT reads 1, 2, 3 on consecutive cycles after the first tick.
- DIV=3, run 12 cycles from RUN entry -> oCOUNT = 3; increments exactly every 4th clock.
- Load 64'hFFFF_FFFF_FFFF_FFFE with DQM=2'b00, DIV=0, IRQENA=1 -> after 2 ticks oCOUNT = 0, oOVF = 1, oIRQ = 1. iOVF_CLEAR on a non-wrap cycle -> oOVF = 0.
- With count 64'h0000_0005_0000_0010, load 64'hAAAA_AAAA_0000_0000 with DQM=2'b01 while stopped -> oCOUNT = 64'hAAAA_AAAA_0000_0010.
- Running, load with DQM=2'b00 and a tick due in the same cycle -> oCOUNT equals the loaded value (load wins); next tick comes DIV+1 cycles later.
- iSNAP_REQ while count = 100, DIV=0 -> next cycle oSNAP_VALID = 1, oSNAP_COUNT = 100 while oCOUNT = 101. Config ENA=0 mid-run -> oWORKING falls and the count freezes.
